// File: rtl/mem_bist_ctrl.sv
// March-C-style BIST controller for a single-port RAM with 1-cycle registered read.
// Optional first-failure capture is built when MEM_BIST_FAIL_CAPTURE_EN is defined.
module mem_bist_ctrl #(
  parameter  int DATA_WIDTH = 8,
  parameter  int RAM_DEPTH  = 8,
  localparam int ADDR_WIDTH = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                  clk_ip,
  input  logic                  rst_ip,
  input  logic                  start_ip,
  input  logic [DATA_WIDTH-1:0] ram_rdata_ip,
  output logic                  ram_we_op,
  output logic [ADDR_WIDTH-1:0] ram_addr_op,
  output logic [DATA_WIDTH-1:0] ram_wdata_op,
  output logic                  busy_op,
  output logic                  done_op,
  output logic                  pass_op,
  output logic                  fail_op,
  output logic [ADDR_WIDTH-1:0] fail_addr_op,
  output logic [1:0]            fail_elem_op,
  output logic [DATA_WIDTH-1:0] fail_data_op
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0_W  = 4'd1;
  localparam logic [3:0] S_M1_R  = 4'd2;
  localparam logic [3:0] S_M1_W  = 4'd3;
  localparam logic [3:0] S_M2_R  = 4'd4;
  localparam logic [3:0] S_M2_W  = 4'd5;
  localparam logic [3:0] S_M3_R  = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] WORD_ONE  = '1;

  logic [3:0]            state;
  logic [3:0]            state_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] pend_exp;
  logic                  is_read;
  logic                  start_ok;
  logic                  mismatch;

  assign is_read  = (state == S_M1_R) || (state == S_M2_R) || (state == S_M3_R);
  assign start_ok = start_ip && ((state == S_IDLE) || (state == S_DONE));
  // The pending register carries the previous cycle's read so it is compared once the RAM has registered it.
  assign mismatch = pend_valid && (ram_rdata_ip != pend_exp);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    addr_nx  = ram_addr_op;
    case (state)
      S_IDLE, S_DONE: begin
        addr_nx = '0;
        if (start_ip) state_nx = S_M0_W;
      end
      S_M0_W: begin
        if (ram_addr_op == ADDR_LAST) begin
          state_nx = S_M1_R;
          addr_nx  = '0;
        end else begin
          addr_nx = ram_addr_op + ADDR_ONE;
        end
      end
      S_M1_R: state_nx = S_M1_W;
      S_M1_W: begin
        if (ram_addr_op == ADDR_LAST) begin
          state_nx = S_M2_R;
          addr_nx  = ADDR_LAST;
        end else begin
          state_nx = S_M1_R;
          addr_nx  = ram_addr_op + ADDR_ONE;
        end
      end
      S_M2_R: state_nx = S_M2_W;
      S_M2_W: begin
        if (ram_addr_op == '0) begin
          state_nx = S_M3_R;
          addr_nx  = '0;
        end else begin
          state_nx = S_M2_R;
          addr_nx  = ram_addr_op - ADDR_ONE;
        end
      end
      S_M3_R: begin
        if (ram_addr_op == ADDR_LAST) state_nx = S_DRAIN;
        else                          addr_nx  = ram_addr_op + ADDR_ONE;
      end
      S_DRAIN: begin
        state_nx = S_DONE;
        addr_nx  = '0;
      end
      default: begin
        state_nx = S_IDLE;
        addr_nx  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_ip) begin
    if (rst_ip) begin
      state        <= S_IDLE;
      ram_we_op    <= 1'b0;
      ram_addr_op  <= '0;
      ram_wdata_op <= '0;
      busy_op      <= 1'b0;
      done_op      <= 1'b0;
      pass_op      <= 1'b0;
      fail_op      <= 1'b0;
      pend_valid   <= 1'b0;
      pend_exp     <= '0;
    end else begin
      state        <= state_nx;
      ram_addr_op  <= addr_nx;
      ram_we_op    <= (state_nx == S_M0_W) || (state_nx == S_M1_W) || (state_nx == S_M2_W);
      ram_wdata_op <= (state_nx == S_M1_W) ? WORD_ONE : WORD_ZERO;
      busy_op      <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      pend_valid   <= is_read;
      pend_exp     <= (state == S_M2_R) ? WORD_ONE : WORD_ZERO;
      if (start_ok) begin
        done_op <= 1'b0;
        pass_op <= 1'b0;
        fail_op <= 1'b0;
      end else begin
        if (mismatch) fail_op <= 1'b1;
        // The last M3 compare lands on the DRAIN edge, so pass must include it.
        if (state == S_DRAIN) begin
          done_op <= 1'b1;
          pass_op <= !(fail_op || mismatch);
        end
      end
    end
  end

`ifdef MEM_BIST_FAIL_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [1:0]            pend_elem;
  logic [1:0]            elem_cur;

  always_comb begin
    elem_cur = 2'd0;
    case (state)
      S_M1_R:  elem_cur = 2'd1;
      S_M2_R:  elem_cur = 2'd2;
      S_M3_R:  elem_cur = 2'd3;
      default: elem_cur = 2'd0;
    endcase
  end

  always_ff @(posedge clk_ip) begin
    if (rst_ip) begin
      pend_addr    <= '0;
      pend_elem    <= 2'd0;
      fail_addr_op <= '0;
      fail_elem_op <= 2'd0;
      fail_data_op <= '0;
    end else begin
      pend_addr <= ram_addr_op;
      pend_elem <= elem_cur;
      if (start_ok) begin
        fail_addr_op <= '0;
        fail_elem_op <= 2'd0;
        fail_data_op <= '0;
      end else if (mismatch && !fail_op) begin
        fail_addr_op <= pend_addr;
        fail_elem_op <= pend_elem;
        fail_data_op <= ram_rdata_ip;
      end
    end
  end
`else
  assign fail_addr_op = '0;
  assign fail_elem_op = 2'd0;
  assign fail_data_op = '0;
`endif

endmodule
